n64_controller_port: RTL
========================

Name: n64_controller_port

Overview:
- Parametrised next-generation N64 controller emulator for one console port.
- Integrates the bit-level joybus receiver, command decoder, response delay and serialiser in one FSM, so the separate identity and state transmitters are no longer needed.
- Adds configurable timing, programmable identity, frame-source underflow policy, receive timeout/abort, and poll/underflow statistics.
- Sits between the per-port frame queue (or the live controller path) and the open-drain data pad.

Parameters:
- CLK_PER_US, 50: sys_clk cycles per microsecond.
- RESP_DELAY_US, 2: line-high gap between the command stop bit and the first response bit.
- IDENT, 24'h050002: 3-byte identity reply, sent MSB first.
- REPEAT_LAST, 1: on underflow, 1 = resend the last TAS frame, 0 = send all zeros.
- RX_TIMEOUT_US, 8: abort limit for a mid-command line-idle or line-stuck condition.
- COUNT_W, 16: width of the statistics counters.

Ports:
- sys_clk  in  1  system clock
- controller_reset_n  in  1  asynchronous active-low reset
- n64d_in  in  1  filtered, synchronised data line level
- n64d_oe  out  1  1 = pull the pad low; 0 = release it (pad is open-drain)
- input_mode  in  1  1 = TAS frames from the queue, 0 = real_controller_data
- real_controller_data  in  32  live controller state
- frame_data  in  32  queue head word
- frame_valid  in  1  queue non-empty
- frame_ready  out  1  one-cycle pop strobe
- poll_count  out  COUNT_W  number of answered 0x01 polls, saturating
- underflow_count  out  COUNT_W  number of TAS polls made with frame_valid=0, saturating
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, controller_reset_n=0):
  - Outputs: n64d_oe=0, frame_ready=0, both counters=0, busy=0.
  - Internal: state=IDLE, last_frame=0, shift register=0.
  - Reset asserted mid-transmission releases the line immediately. No partial state survives.
- Timing units: U = CLK_PER_US cycles. All timers count sys_clk cycles.
- States: IDLE, RX_BIT, RX_STOP, IGNORE, DELAY, TX_LOW, TX_HIGH, TX_STOP.
- IDLE:
  - A falling edge on n64d_in (previous sample 1, current 0) enters RX_BIT.
  - Clears the bit counter and the timer.
- RX_BIT:
  - Timer restarts at every falling edge.
  - At timer = 2U the block samples n64d_in and shifts it into cmd, MSB first.
  - After 8 sampled bits it goes to RX_STOP.
  - If the line stays low, or stays high, for RX_TIMEOUT_US*U cycles: return to IDLE, no response, counters unchanged.
- RX_STOP:
  - Waits for the stop bit: a falling edge, then a rising edge.
  - cmd=0x00 or 0xFF: go to DELAY with the identity payload (24 bits).
  - cmd=0x01: go to DELAY with the poll payload (32 bits).
  - Any other cmd: go to IGNORE.
  - The timeout rule from RX_BIT applies here too.
- IGNORE:
  - Waits until the line has been continuously high for RX_TIMEOUT_US*U cycles, then returns to IDLE.
  - Covers trailing bytes of 0x02/0x03 commands.
- DELAY entry cycle, for a poll only:
  - input_mode=0: payload = real_controller_data.
  - input_mode=1 and frame_valid=1: payload = frame_data, last_frame <= frame_data, frame_ready=1 for exactly this one cycle.
  - input_mode=1 and frame_valid=0: payload = REPEAT_LAST ? last_frame : 0, underflow_count += 1, frame_ready stays 0.
  - poll_count += 1 on every poll, in either mode.
  - Both counters saturate at all-ones.
- DELAY: holds n64d_oe=0 for RESP_DELAY_US*U cycles, then goes to TX_LOW.
- Transmit, per bit, MSB first:
  - TX_LOW: n64d_oe=1 for 1U if the bit is 1, or 3U if the bit is 0.
  - TX_HIGH: n64d_oe=0 for 3U if the bit is 1, or 1U if the bit is 0.
  - Every bit cell is exactly 4U.
- After the last bit, TX_STOP: n64d_oe=1 for 2U, then release the line.
- After TX_STOP: wait 1U with the line released, then go to IDLE.
- n64d_in is ignored from DELAY through TX_STOP. An input_mode change during a response affects the next poll only.
- Frame sources: frame_data is sampled only on the frame_ready cycle. real_controller_data is sampled only on the DELAY entry cycle.

Test Plan:
- Poll with a queued frame: queue holds 32'h8000_1234, input_mode=1, console sends 0x01 plus stop -> frame_ready pulses once; after 2U of line high, 32 bits are sent with 1U/3U low pulses matching 0x80001234, then 2U stop; poll_count=1.
- Identity: console sends 0xFF, then later 0x00 -> each returns 24 bits 0x050002 plus stop; poll_count=0; frame_ready never pulses.
- Underflow: REPEAT_LAST=1, one frame 32'hDEAD_BEEF queued, three polls -> all three replies are 0xDEADBEEF; underflow_count=2; poll_count=3. Repeat with REPEAT_LAST=0 -> second and third replies are 0x00000000.
- Unknown command and timeout:
  - 0x03 followed by 33 bytes -> n64d_oe stays 0 throughout, block returns to IDLE.
  - 4 command bits then 10us of line high -> abort with no reply; the next 0x01 is answered normally.
- Reset mid-transmit: controller_reset_n pulled low at bit 10 of a poll reply -> n64d_oe=0 asynchronously; counters=0; next poll under input_mode=0 returns real_controller_data.
- Counter saturation: COUNT_W=2, five polls -> poll_count stays 3; underflow_count also saturates at 3.

Source files
------------

// File: rtl/n64_controller_port_if.sv
// Frame-source side of one N64 controller port: per-port queue head handshake
// plus the live controller state and the source selector.
interface n64_controller_port_if;
    logic        input_mode;
    logic [31:0] real_controller_data;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output input_mode, real_controller_data, frame_data, frame_valid,
        input  frame_ready
    );

    modport slave (
        input  input_mode, real_controller_data, frame_data, frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/n64_controller_port.sv
// N64 controller emulator for one console port: joybus receive, command decode,
// response delay and serialisation in a single FSM, plus poll/underflow statistics.
module n64_controller_port #(
    parameter int unsigned CLK_PER_US    = 50,
    parameter int unsigned RESP_DELAY_US = 2,
    parameter logic [23:0] IDENT         = 24'h050002,
    parameter bit          REPEAT_LAST   = 1'b1,
    parameter int unsigned RX_TIMEOUT_US = 8,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic                 sys_clk,
    input  logic                 controller_reset_n,
    input  logic                 n64d_in,
    output logic                 n64d_oe,
    n64_controller_port_if.slave src,
    output logic [COUNT_W-1:0]   poll_count,
    output logic [COUNT_W-1:0]   underflow_count,
    output logic                 busy
);

    localparam int unsigned U       = CLK_PER_US;
    localparam int unsigned TO_CYC  = RX_TIMEOUT_US * U;
    localparam int unsigned DLY_CYC = RESP_DELAY_US * U;
    localparam int unsigned TW      = $clog2(TO_CYC + DLY_CYC + 4 * U + 1);

    localparam logic [TW-1:0] T_1U_END  = TW'(U - 1);
    localparam logic [TW-1:0] T_2U_END  = TW'(2 * U - 1);
    localparam logic [TW-1:0] T_3U_END  = TW'(3 * U - 1);
    localparam logic [TW-1:0] T_SAMPLE  = TW'(2 * U);
    localparam logic [TW-1:0] T_DLY_END = TW'(DLY_CYC - 1);
    localparam logic [TW-1:0] T_TO_END  = TW'(TO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, RX_BIT, RX_STOP, IGNORE, DELAY, TX_LOW, TX_HIGH, TX_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [31:0]        shift_q, shift_d;
    logic [31:0]        last_frame_q, last_frame_d;
    logic               poll_q, poll_d;
    logic               stop_fall_q, stop_fall_d;
    logic               prev_in_q;
    logic               n64d_oe_q, n64d_oe_d;
    logic [COUNT_W-1:0] poll_count_q, poll_count_d;
    logic [COUNT_W-1:0] underflow_count_q, underflow_count_d;

    logic          fall, rise, timed_out, frame_ready;
    logic [TW-1:0] low_end, high_end;
    logic [5:0]    last_bit;

    assign fall      = prev_in_q & ~n64d_in;
    assign rise      = ~prev_in_q & n64d_in;
    // idle_q counts cycles since the last line edge in either direction.
    assign timed_out = (idle_q >= T_TO_END);
    assign low_end   = shift_q[31] ? T_1U_END : T_3U_END;
    assign high_end  = shift_q[31] ? T_3U_END : T_1U_END;
    assign last_bit  = poll_q ? 6'd31 : 6'd23;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no branch can infer a latch.
        state_d           = state_q;
        timer_d           = (timer_q == '1) ? timer_q : timer_q + TW'(1);
        idle_d            = (fall || rise) ? '0 : ((idle_q == '1) ? idle_q : idle_q + TW'(1));
        bit_cnt_d         = bit_cnt_q;
        cmd_d             = cmd_q;
        shift_d           = shift_q;
        last_frame_d      = last_frame_q;
        poll_d            = poll_q;
        stop_fall_d       = stop_fall_q;
        poll_count_d      = poll_count_q;
        underflow_count_d = underflow_count_q;
        frame_ready       = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                idle_d    = '0;
                bit_cnt_d = '0;
                if (fall) state_d = RX_BIT;
            end
            RX_BIT: begin
                if (fall) timer_d = '0;
                if (timed_out) begin
                    state_d = IDLE;
                end else if (timer_q == T_SAMPLE) begin
                    cmd_d     = {cmd_q[6:0], n64d_in};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd7) begin
                        state_d     = RX_STOP;
                        stop_fall_d = 1'b0;
                    end
                end
            end
            RX_STOP: begin
                // A rising edge before the stop bit's own falling edge is the tail of a 0 bit.
                if (timed_out) begin
                    state_d = IDLE;
                end else if (fall) begin
                    stop_fall_d = 1'b1;
                end else if (rise && stop_fall_q) begin
                    timer_d = '0;
                    if (cmd_q == 8'h00 || cmd_q == 8'hFF) begin
                        poll_d  = 1'b0;
                        state_d = DELAY;
                    end else if (cmd_q == 8'h01) begin
                        poll_d  = 1'b1;
                        state_d = DELAY;
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            IGNORE: begin
                if (n64d_in && timed_out) state_d = IDLE;
            end
            DELAY: begin
                if (timer_q == '0) begin
                    if (!poll_q) begin
                        shift_d = {IDENT, 8'h00};
                    end else begin
                        poll_count_d = (poll_count_q == '1) ? poll_count_q
                                                            : poll_count_q + COUNT_W'(1);
                        if (!src.input_mode) begin
                            shift_d = src.real_controller_data;
                        end else if (src.frame_valid) begin
                            shift_d      = src.frame_data;
                            last_frame_d = src.frame_data;
                            frame_ready  = 1'b1;
                        end else begin
                            shift_d           = REPEAT_LAST ? last_frame_q : 32'h0;
                            underflow_count_d = (underflow_count_q == '1) ? underflow_count_q
                                                : underflow_count_q + COUNT_W'(1);
                        end
                    end
                end
                if (timer_q == T_DLY_END) begin
                    state_d   = TX_LOW;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            TX_LOW: begin
                if (timer_q == low_end) begin
                    state_d = TX_HIGH;
                    timer_d = '0;
                end
            end
            TX_HIGH: begin
                if (timer_q == high_end) begin
                    timer_d   = '0;
                    shift_d   = {shift_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == last_bit) ? TX_STOP : TX_LOW;
                end
            end
            TX_STOP: begin
                // 2U of stop pulse followed by 1U of released line.
                if (timer_q == T_3U_END) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        n64d_oe_d = (state_d == TX_LOW) || (state_d == TX_STOP && timer_d <= T_2U_END);
    end

    // NOTE: sequential state uses non-blocking assignments only; the asynchronous
    // reset releases the pad immediately, even mid-bit.
    always_ff @(posedge sys_clk or negedge controller_reset_n) begin
        if (!controller_reset_n) begin
            state_q           <= IDLE;
            timer_q           <= '0;
            idle_q            <= '0;
            bit_cnt_q         <= '0;
            cmd_q             <= '0;
            shift_q           <= '0;
            last_frame_q      <= '0;
            poll_q            <= 1'b0;
            stop_fall_q       <= 1'b0;
            prev_in_q         <= 1'b1;
            n64d_oe_q         <= 1'b0;
            poll_count_q      <= '0;
            underflow_count_q <= '0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            idle_q            <= idle_d;
            bit_cnt_q         <= bit_cnt_d;
            cmd_q             <= cmd_d;
            shift_q           <= shift_d;
            last_frame_q      <= last_frame_d;
            poll_q            <= poll_d;
            stop_fall_q       <= stop_fall_d;
            prev_in_q         <= n64d_in;
            n64d_oe_q         <= n64d_oe_d;
            poll_count_q      <= poll_count_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    assign n64d_oe         = n64d_oe_q;
    assign src.frame_ready = frame_ready;
    assign poll_count      = poll_count_q;
    assign underflow_count = underflow_count_q;
    assign busy            = (state_q != IDLE);

endmodule
